// File: rtl/rom_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : rom_fetch_unit
// Brief    : Instruction fetch stage for a synchronous-read ROM. Absorbs the
//            one-cycle read latency and buffers words behind a valid/ready
//            handshake. Redirects flush buffered and in-flight fetches.
// Revision : 1.0 - initial release
// ============================================================================
module rom_fetch_unit #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RESET_PC   = 0,
    parameter int ROM_BYTES  = 4096,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              rom_ena,
    output logic [ADDR_W-1:0] rom_addra,
    input  logic [DATA_W-1:0] rom_douta,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_ready,
    output logic              misalign_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] c_pc_mask  = ADDR_W'(ROM_BYTES - 1);
    localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);
    localparam logic [CW:0]       c_depth    = (CW+1)'(FIFO_DEPTH);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_tag_addr;
    logic              r_inflight;
    logic              r_kill;
    logic              r_misalign;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];

    logic [CW:0]       w_occupancy;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;
    logic [ADDR_W-1:0] w_redirect_pc;

    // Occupancy counts the in-flight word so the FIFO always has room for it.
    assign w_occupancy   = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue       = rst_n & fetch_en & ~redirect_valid & (w_occupancy < c_depth);
    assign w_valid       = (r_count != '0);
    assign w_pop         = w_valid & instr_ready;
    assign w_push        = r_inflight & ~r_kill & ~redirect_valid;
    assign w_redirect_pc = {redirect_addr[ADDR_W-1:2], 2'b00} & c_pc_mask;

    assign rom_ena      = w_issue;
    assign rom_addra    = r_pc;
    assign instr_valid  = w_valid;
    assign instr_data   = w_valid ? r_mem_data[r_rd_ptr] : '0;
    assign instr_addr   = w_valid ? r_mem_addr[r_rd_ptr] : '0;
    assign misalign_err = r_misalign;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= c_reset_pc;
            r_tag_addr <= '0;
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
            r_misalign <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc       <= (r_pc + ADDR_W'(4)) & c_pc_mask;
                r_tag_addr <= r_pc;
            end
            if (redirect_valid) begin
                r_pc     <= w_redirect_pc;
                r_kill   <= r_inflight | r_kill;
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                if (redirect_addr[1:0] != 2'b00) begin
                    r_misalign <= 1'b1;
                end
            end else begin
                r_kill  <= 1'b0;
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: outputs are masked to zero while empty.
    always_ff @(posedge clka) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= rom_douta;
            r_mem_addr[r_wr_ptr] <= r_tag_addr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rom_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_fetch_unit
// Brief    : Directed self-checking bench for rom_fetch_unit with ROM models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_fetch_unit;

    logic        clka = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        rom_ena;
    logic [31:0] rom_addra;
    logic [31:0] rom_douta = '0;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_addr;
    logic        instr_ready = 1'b1;
    logic        misalign_err;

    logic        s_rom_ena;
    logic [31:0] s_rom_addra;
    logic [31:0] s_rom_douta = '0;
    logic        s_instr_valid;
    logic [31:0] s_instr_data;
    logic [31:0] s_instr_addr;
    logic        s_misalign_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clka = ~clka;

    rom_fetch_unit u_dut (
        .clka(clka), .rst_n(rst_n), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .rom_ena(rom_ena), .rom_addra(rom_addra), .rom_douta(rom_douta),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_addr(instr_addr),
        .instr_ready(instr_ready), .misalign_err(misalign_err)
    );

    rom_fetch_unit #(.ROM_BYTES(16)) u_dut_small (
        .clka(clka), .rst_n(rst_n), .fetch_en(1'b1),
        .redirect_valid(1'b0), .redirect_addr(32'h0),
        .rom_ena(s_rom_ena), .rom_addra(s_rom_addra), .rom_douta(s_rom_douta),
        .instr_valid(s_instr_valid), .instr_data(s_instr_data), .instr_addr(s_instr_addr),
        .instr_ready(1'b1), .misalign_err(s_misalign_err)
    );

    // ROM models: word at byte address a holds a/4.
    always @(posedge clka) begin
        if (rom_ena)   rom_douta   <= rom_addra >> 2;
        if (s_rom_ena) s_rom_douta <= s_rom_addra >> 2;
    end

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clka);
        #3;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clka);
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] a, input logic [31:0] d);
        check_vec({tag, "_valid"}, 64'(instr_valid), 64'd1);
        check_vec({tag, "_addr"}, 64'(instr_addr), 64'(a));
        check_vec({tag, "_data"}, 64'(instr_data), 64'(d));
    endtask

    initial begin
        int n_ena;
        // Reset values
        #12;
        check_vec("rst_ena", 64'(rom_ena), 64'd0);
        check_vec("rst_addra", 64'(rom_addra), 64'd0);
        check_vec("rst_valid", 64'(instr_valid), 64'd0);
        check_vec("rst_data", 64'(instr_data), 64'd0);
        check_vec("rst_addr", 64'(instr_addr), 64'd0);
        check_vec("rst_misalign", 64'(misalign_err), 64'd0);

        // Streaming at full rate, plus the 16-byte wrapping instance
        fetch_en = 1'b1; instr_ready = 1'b1;
        do_reset();
        check_vec("s1_ena0", 64'(rom_ena), 64'd1);
        check_vec("s1_addra0", 64'(rom_addra), 64'd0);
        check_vec("s1_valid0", 64'(instr_valid), 64'd0);
        step();
        check_vec("s1_addra1", 64'(rom_addra), 64'd4);
        check_vec("s1_valid1", 64'(instr_valid), 64'd0);
        step();
        check_vec("s1_addra2", 64'(rom_addra), 64'd8);
        for (int k = 0; k < 6; k++) begin
            check_head("s1_head", 32'(4 * k), 32'(k));
            check_vec("wrap_valid", 64'(s_instr_valid), 64'd1);
            check_vec("wrap_addr", 64'(s_instr_addr), 64'((4 * k) % 16));
            check_vec("wrap_data", 64'(s_instr_data), 64'(k % 4));
            step();
        end

        // Back-pressure from the start
        instr_ready = 1'b0;
        do_reset();
        n_ena = 0;
        for (int k = 0; k < 10; k++) begin
            if (rom_ena) n_ena++;
            if (k < 9) step();
        end
        check_vec("bp_ena_count", 64'(n_ena), 64'd4);
        check_vec("bp_ena_low", 64'(rom_ena), 64'd0);
        check_head("bp_hold", 32'd0, 32'd0);
        instr_ready = 1'b1;
        #1;
        check_head("bp_pop0", 32'd0, 32'd0);
        step();
        check_head("bp_pop1", 32'd4, 32'd1);
        check_vec("bp_resume_ena", 64'(rom_ena), 64'd1);
        check_vec("bp_resume_addra", 64'(rom_addra), 64'd16);
        step();
        check_head("bp_pop2", 32'd8, 32'd2);
        step();
        check_head("bp_pop3", 32'd12, 32'd3);
        step();
        check_head("bp_pop4", 32'd16, 32'd4);

        // Redirect with one in flight and two buffered
        instr_ready = 1'b0;
        do_reset();
        step(); step(); step();
        check_head("rd_pre", 32'd0, 32'd0);
        redirect_valid = 1'b1; redirect_addr = 32'h40;
        #1;
        check_vec("rd_ena_blocked", 64'(rom_ena), 64'd0);
        step();
        redirect_valid = 1'b0; instr_ready = 1'b1;
        #1;
        check_vec("rd_valid0", 64'(instr_valid), 64'd0);
        check_vec("rd_addra", 64'(rom_addra), 64'h40);
        check_vec("rd_ena", 64'(rom_ena), 64'd1);
        step();
        check_vec("rd_valid1", 64'(instr_valid), 64'd0);
        step();
        check_head("rd_first", 32'h40, 32'd16);
        check_vec("rd_misalign", 64'(misalign_err), 64'd0);

        // Misaligned redirect
        redirect_valid = 1'b1; redirect_addr = 32'h42;
        step();
        redirect_valid = 1'b0;
        #1;
        check_vec("mis_flag", 64'(misalign_err), 64'd1);
        check_vec("mis_addra", 64'(rom_addra), 64'h40);
        check_vec("mis_valid0", 64'(instr_valid), 64'd0);
        step();
        step();
        check_head("mis_first", 32'h40, 32'd16);
        step();
        check_head("mis_second", 32'h44, 32'd17);
        check_vec("mis_sticky", 64'(misalign_err), 64'd1);

        // Reset mid-operation: FIFO at 2 with a word in flight
        instr_ready = 1'b0;
        redirect_valid = 1'b1; redirect_addr = 32'h80;
        step();
        redirect_valid = 1'b0;
        step(); step(); step();
        check_head("mr_pre", 32'h80, 32'd32);
        check_vec("mr_pre_misalign", 64'(misalign_err), 64'd1);
        rst_n = 1'b0;
        #1;
        check_vec("mr_valid", 64'(instr_valid), 64'd0);
        check_vec("mr_data", 64'(instr_data), 64'd0);
        check_vec("mr_addr", 64'(instr_addr), 64'd0);
        check_vec("mr_ena", 64'(rom_ena), 64'd0);
        check_vec("mr_addra", 64'(rom_addra), 64'd0);
        check_vec("mr_misalign", 64'(misalign_err), 64'd0);
        instr_ready = 1'b1;
        do_reset();
        check_vec("mr_post_valid0", 64'(instr_valid), 64'd0);
        check_vec("mr_post_addra", 64'(rom_addra), 64'd0);
        step();
        check_vec("mr_post_valid1", 64'(instr_valid), 64'd0);
        step();
        check_head("mr_post_first", 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
